sdram_responder: RTL and testbench
==================================

// Module: sdram_responder
// PURPOSE
//  Responder (memory side) of the cache controller's SDRAM strobe interface. Accepts one
//  word transaction per mstrb_sdram pulse from cache_top and writes or reads an internal
//  byte array after a fixed latency. Drives DOut_sdram and a ready flag back to the cache.
//  Used as the SDRAM stand-in for simulation and for the ChipScope board build.
// PARAMETERS
//  ADDR_WIDTH      16     width of Address_sdram
//  DATA_WIDTH      8      word width of din_sdram/DOut_sdram
//  MEM_ADDR_WIDTH  10     internal array index width; DEPTH = 2**MEM_ADDR_WIDTH
//  LATENCY         2      clocks from accepted strobe to completion; legal range >= 1
//  INIT_SEED       8'hA5  init pattern: mem[i] = i[DATA_WIDTH-1:0] ^ INIT_SEED
// PORTS
//  clk            in   1           single clock; all logic on posedge
//  rst            in   1           synchronous, active-high reset
//  Address_sdram  in   ADDR_WIDTH  word address; only bits [MEM_ADDR_WIDTH-1:0] used (aliases)
//  wr_rd_sdram    in   1           1 = write, 0 = read; sampled with mstrb_sdram
//  mstrb_sdram    in   1           one-cycle transaction strobe from cache_top
//  din_sdram      in   DATA_WIDTH  write data from cache_top; sampled with mstrb_sdram
//  DOut_sdram     out  DATA_WIDTH  read data to cache_top; holds last read value
//  rdy_sdram      out  1           1 = idle, next strobe accepted
//  init_done      out  1           1 once the init sweep has finished
//  err_sdram      out  1           sticky: a strobe arrived when not IDLE
//  state          out  2           FSM state for ILA: 0 INIT, 1 IDLE, 2 BUSY
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=INIT, ptr=0, cnt=0, DOut_sdram=0, rdy_sdram=0,
//   init_done=0, err_sdram=0. Reset has priority over every other action. Array contents
//   are not cleared by reset; INIT rewrites them.
//  INIT: each edge writes mem[ptr] <= ptr[DATA_WIDTH-1:0]^INIT_SEED and increments ptr.
//   On the edge that writes ptr==DEPTH-1: state<=IDLE, rdy_sdram<=1, init_done<=1.
//   init_done therefore rises DEPTH edges after the last edge with rst=1.
//  IDLE: mstrb_sdram=1 at an edge -> latch addr[MEM_ADDR_WIDTH-1:0], wr_rd, din;
//   cnt<=LATENCY-1; rdy_sdram<=0; state<=BUSY.
//  BUSY: if cnt!=0 then cnt<=cnt-1. If cnt==0: write -> mem[addr]<=data, DOut unchanged;
//   read -> DOut_sdram<=mem[addr]. rdy_sdram<=1; state<=IDLE.
//  Timing: strobe sampled at edge T -> DOut_sdram valid and rdy_sdram=1 after edge T+LATENCY.
//   rdy_sdram is low for exactly LATENCY cycles. Max throughput: one transaction per
//   LATENCY+1 clocks.
//  Acceptance rule: a strobe is accepted only when state==IDLE at the sampling edge.
//   A strobe in INIT or BUSY, including the BUSY completion edge, is dropped and sets
//   err_sdram<=1. err_sdram stays 1 until rst.
//  Read-after-write to the same address returns the new data (write commits before IDLE).
//  Reset mid-INIT or mid-BUSY: the pending transaction is discarded (a pending write
//   never commits) and the init sweep restarts from ptr=0.
//  Address aliasing: Address_sdram bits above MEM_ADDR_WIDTH-1 are ignored. No error.
// TESTING (defaults unless stated)
//  1 Pulse rst for 1 clk -> state=0, rdy=0 during sweep; init_done=1, rdy=1, state=1
//    exactly 1024 clks after the rst edge.
//  2 Read 0x0003 -> rdy low 2 cycles; DOut=0xA6 and rdy=1 after edge T+2; DOut then holds.
//  3 Write 0x0010 data 0x5C, then read 0x0010 -> DOut unchanged by the write; read returns 0x5C.
//  4 Read 0x0403 (aliases to 0x003) -> 0xA6. Read 0xFFFF -> 0xFF^0xA5 = 0x5A.
//  5 Strobe during BUSY, on the completion edge, and during INIT -> each is dropped,
//    err_sdram=1 and sticky, array and DOut unaffected; after rst err_sdram=0.
//  6 Write 0x0020=0x11, assert rst while BUSY -> after init, read 0x0020 = 0x85; run with
//    LATENCY=1 -> back-to-back reads every 2 clks complete after 1 edge each.

Source files
------------

// File: rtl/sdram_responder.sv
// Memory-side responder for the cache's SDRAM strobe interface: after an init sweep fills the
// array, it completes one word read or write per strobe after a fixed latency.
module sdram_responder #(
   parameter int                    ADDR_WIDTH     = 16,
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    MEM_ADDR_WIDTH = 10,
   parameter int                    LATENCY        = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_SEED      = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] Address_sdram,
   input  logic                  wr_rd_sdram,
   input  logic                  mstrb_sdram,
   input  logic [DATA_WIDTH-1:0] din_sdram,
   output logic [DATA_WIDTH-1:0] DOut_sdram,
   output logic                  rdy_sdram,
   output logic                  init_done,
   output logic                  err_sdram,
   output logic [1:0]            state
);

   localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0]          CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [MEM_ADDR_WIDTH-1:0] PTR_LAST = MEM_ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   state_t                    state_reg, state_next;
   logic [MEM_ADDR_WIDTH-1:0] ptr_reg, ptr_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0]     data_reg, data_next;
   logic                      wr_reg, wr_next;
   logic [DATA_WIDTH-1:0]     dout_reg;
   logic                      rdy_reg, rdy_next;
   logic                      init_done_reg, init_done_next;
   logic                      err_reg, err_next;

   logic                      mem_we;
   logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic                      rd_en;

   logic [DATA_WIDTH-1:0]     mem [DEPTH];

   generate
      if (ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_alias
         // High address bits alias onto the array and are deliberately ignored.
         logic unused_addr_bits;
         assign unused_addr_bits = ^Address_sdram[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      cnt_next       = cnt_reg;
      addr_next      = addr_reg;
      data_next      = data_reg;
      wr_next        = wr_reg;
      rdy_next       = rdy_reg;
      init_done_next = init_done_reg;
      err_next       = err_reg;
      mem_we         = 1'b0;
      mem_waddr      = ptr_reg;
      mem_wdata      = DATA_WIDTH'(ptr_reg) ^ INIT_SEED;
      rd_en          = 1'b0;

      case (state_reg)
         ST_INIT: begin
            mem_we   = 1'b1;
            ptr_next = ptr_reg + 1'b1;
            if (ptr_reg == PTR_LAST) begin
               state_next     = ST_IDLE;
               rdy_next       = 1'b1;
               init_done_next = 1'b1;
            end
         end
         ST_IDLE: begin
            if (mstrb_sdram) begin
               addr_next  = Address_sdram[MEM_ADDR_WIDTH-1:0];
               wr_next    = wr_rd_sdram;
               data_next  = din_sdram;
               cnt_next   = CNT_LOAD;
               rdy_next   = 1'b0;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               // Write commits on the completion edge so a following read sees it.
               mem_we     = wr_reg;
               mem_waddr  = addr_reg;
               mem_wdata  = data_reg;
               rd_en      = !wr_reg;
               rdy_next   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_INIT;
      endcase

      if (mstrb_sdram && state_reg != ST_IDLE)
         err_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_INIT;
         ptr_reg       <= '0;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         data_reg      <= '0;
         wr_reg        <= 1'b0;
         dout_reg      <= '0;
         rdy_reg       <= 1'b0;
         init_done_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         cnt_reg       <= cnt_next;
         addr_reg      <= addr_next;
         data_reg      <= data_next;
         wr_reg        <= wr_next;
         rdy_reg       <= rdy_next;
         init_done_reg <= init_done_next;
         err_reg       <= err_next;
         if (rd_en)
            dout_reg <= mem[addr_reg];
      end
   end

   // Array is never cleared by reset; a write pending when reset hits is dropped.
   always_ff @(posedge clk) begin
      if (mem_we && !rst)
         mem[mem_waddr] <= mem_wdata;
   end

   assign DOut_sdram = dout_reg;
   assign rdy_sdram  = rdy_reg;
   assign init_done  = init_done_reg;
   assign err_sdram  = err_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder against a transaction-level memory model;
// a second instance with LATENCY=1 checks back-to-back reads.
module tb_sdram_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, addr1;
   logic        wr, mstrb, mstrb1;
   logic        wr1 = 1'b0;
   logic [7:0]  din;
   logic [7:0]  din1 = 8'h00;
   logic [7:0]  dout, dout1;
   logic        rdy, rdy1, idone, idone1, err, err1;
   logic [1:0]  st, st1;

   logic [7:0]  model_mem [1024];
   logic [7:0]  model_dout;
   logic        model_err;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   sdram_responder #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .Address_sdram(addr), .wr_rd_sdram(wr),
      .mstrb_sdram(mstrb), .din_sdram(din), .DOut_sdram(dout), .rdy_sdram(rdy),
      .init_done(idone), .err_sdram(err), .state(st)
   );

   sdram_responder #(.LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .Address_sdram(addr1), .wr_rd_sdram(wr1),
      .mstrb_sdram(mstrb1), .din_sdram(din1), .DOut_sdram(dout1), .rdy_sdram(rdy1),
      .init_done(idone1), .err_sdram(err1), .state(st1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) model_mem[i] = 8'(i) ^ 8'hA5;
      model_dout = 8'h00;
      model_err  = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; mstrb = 1'b0; mstrb1 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_init();
      for (int i = 0; i < 2000 && !(idone && idone1); i++) @(negedge clk);
      check("init_timeout", idone && idone1, 1'b1);
   endtask

   // One transaction on dut; intrude_at in 1..LAT injects a stray strobe at edge T+intrude_at.
   task automatic txn(input bit w, input logic [15:0] a, input logic [7:0] d, input int intrude_at);
      int idx;
      idx = int'(a[9:0]);
      check("rdy_before", rdy, 1'b1);
      wr = w; addr = a; din = d; mstrb = 1'b1;
      @(posedge clk);
      #1 mstrb = 1'b0;
      if (w) model_mem[idx] = d;
      else   model_dout = model_mem[idx];
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         mstrb = 1'b0;
         check("rdy_busy", rdy, 1'b0);
         if (k + 1 == intrude_at) begin
            wr = 1'b1; din = ~model_mem[idx]; mstrb = 1'b1;
            model_err = 1'b1;
         end
      end
      @(negedge clk);
      mstrb = 1'b0;
      check("rdy_done", rdy, 1'b1);
      check("dout", dout, model_dout);
      check("err", err, model_err);
      check("state_idle", st, 2'd1);
      $display("txn wr=%0d addr=%h din=%h intr=%0d dout=%h exp=%h", w, a, d, intrude_at, dout, model_dout);
   endtask

   initial begin
      rst = 1'b1; mstrb = 1'b0; mstrb1 = 1'b0; wr = 1'b0; addr = '0; din = '0; addr1 = '0;
      model_reset();
      repeat (3) @(posedge clk);

      // Reset pulse and exact init sweep length
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_state", st, 2'd0);
      check("rst_rdy", rdy, 1'b0);
      check("rst_init_done", idone, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_dout", dout, 8'h00);
      for (int k = 1; k <= 1024; k++) begin
         @(negedge clk);
         check("sweep_init_done", idone, k == 1024);
         check("sweep_rdy", rdy, k == 1024);
         check("sweep_state", st, (k == 1024) ? 2'd1 : 2'd0);
      end

      // Basic read, hold, write then read-back, aliasing
      txn(1'b0, 16'h0003, 8'h00, 0);
      check("rd_0003", dout, 8'hA6);
      repeat (3) @(negedge clk);
      check("dout_hold", dout, 8'hA6);
      txn(1'b1, 16'h0010, 8'h5C, 0);
      check("wr_keeps_dout", dout, 8'hA6);
      txn(1'b0, 16'h0010, 8'h00, 0);
      check("rd_0010", dout, 8'h5C);
      txn(1'b0, 16'h0403, 8'h00, 0);
      check("rd_alias_0403", dout, 8'hA6);
      txn(1'b0, 16'hFFFF, 8'h00, 0);
      check("rd_ffff", dout, 8'h5A);

      // Stray strobes during BUSY and on the completion edge
      txn(1'b0, 16'h0030, 8'h00, 1);
      txn(1'b0, 16'h0031, 8'h00, LAT);
      check("err_sticky", err, 1'b1);
      txn(1'b0, 16'h0030, 8'h00, 0);
      txn(1'b0, 16'h0031, 8'h00, 0);

      // Stray strobe during INIT, then reset clears err
      apply_reset();
      repeat (5) @(negedge clk);
      wr = 1'b1; addr = 16'h0005; din = 8'h00; mstrb = 1'b1;
      @(posedge clk);
      #1 mstrb = 1'b0;
      model_err = 1'b1;
      wait_init();
      check("err_from_init", err, 1'b1);
      txn(1'b0, 16'h0005, 8'h00, 0);
      check("rd_0005", dout, 8'hA0);
      apply_reset();
      @(negedge clk);
      check("err_cleared", err, 1'b0);
      wait_init();

      // Randomized traffic with occasional stray strobes
      for (int n = 0; n < 80; n++) begin
         int intr;
         intr = int'($urandom_range(0, 5));
         if (intr > LAT) intr = 0;
         txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), intr);
      end

      // Reset while a write is pending: it must never commit
      @(negedge clk);
      wr = 1'b1; addr = 16'h0020; din = 8'h11; mstrb = 1'b1;
      @(posedge clk);
      #1 mstrb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      wait_init();
      txn(1'b0, 16'h0020, 8'h00, 0);
      check("rd_0020_after_rst", dout, 8'h85);

      // LATENCY=1 instance: back-to-back reads every 2 clocks
      for (int n = 0; n < 8; n++) begin
         logic [15:0] a;
         a = 16'($urandom);
         addr1 = a; mstrb1 = 1'b1;
         @(posedge clk);
         #1 mstrb1 = 1'b0;
         @(negedge clk);
         check("lat1_busy", rdy1, 1'b0);
         @(negedge clk);
         check("lat1_rdy", rdy1, 1'b1);
         check("lat1_dout", dout1, 8'(a[9:0]) ^ 8'hA5);
         $display("txn lat1 addr=%h dout=%h", a, dout1);
      end
      check("lat1_err", err1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
